// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: shared coordinate/metadata types, drop counter limit and width helpers
package pixel_stream_pkg;
  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;
  typedef logic [15:0] coord_t;
  typedef struct packed {
    coord_t row;
    coord_t col;
    logic   sof;
    logic   eol;
  } pixel_meta_t;
  function automatic int ch_w(input int m, input int n, input int s);
    return m + n + s;
  endfunction
  function automatic int pix_w(input int m, input int n, input int s, input int ch);
    return ch * ch_w(m, n, s);
  endfunction
endpackage

// File: rtl/pixel_stream_if.sv
// pixel_stream_if: legacy valid-only input bus, ready/valid output stream and status flags
interface pixel_stream_if #(
  parameter int PIX_W = 8,
  parameter int LVL_W = 5
);
  import pixel_stream_pkg::*;
  logic [PIX_W-1:0] in_pixel;
  logic             in_valid;
  coord_t           in_row;
  coord_t           in_col;
  logic [PIX_W-1:0] out_pixel;
  logic             out_valid;
  logic             out_ready;
  coord_t           out_row;
  coord_t           out_col;
  logic             out_sof;
  logic             out_eol;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic [15:0]      drop_cnt;
  logic             clr_flags;
  logic             coord_err;
  modport master (
    output in_pixel, in_valid, in_row, in_col, out_ready, clr_flags,
    input  out_pixel, out_valid, out_row, out_col, out_sof, out_eol, level, overflow, drop_cnt, coord_err
  );
  modport slave (
    input  in_pixel, in_valid, in_row, in_col, out_ready, clr_flags,
    output out_pixel, out_valid, out_row, out_col, out_sof, out_eol, level, overflow, drop_cnt, coord_err
  );
endinterface

// File: rtl/pixel_sync_fifo.sv
// pixel_sync_fifo: synchronous FIFO with registered storage, head-of-queue output and occupancy
module pixel_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [W-1:0]            wdata_i,
  output logic [W-1:0]            rdata_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    full_o,
  output logic                    empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  // next pointers/occupancy; pointer width makes the wrap modulo DEPTH implicit
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_i);
    level_d  = level_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end
  // storage needs no reset: the head is masked to zero while the queue is empty
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  // pointer and occupancy registers, all cleared by reset
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  assign empty_o = level_q == '0;
  assign full_o  = level_q == (AW+1)'(DEPTH);
  assign level_o = level_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/pixel_stream_bridge.sv
// pixel_stream_bridge: valid-only pixel bus to ready/valid stream with frame markers and drop
// accounting; define PIXEL_BRIDGE_COORD_CHECK_EN to build the raster-order coordinate checker
module pixel_stream_bridge
  import pixel_stream_pkg::*;
#(
  parameter int FP_M    = 8,
  parameter int FP_N    = 0,
  parameter int FP_S    = 0,
  parameter int NUM_CH  = 1,
  parameter int DEPTH   = 16,
  parameter int FRAME_W = 640
) (
  input logic           clk,
  input logic           rst_n,
  pixel_stream_if.slave bus
);
  localparam int PIX_W = pix_w(FP_M, FP_N, FP_S, NUM_CH);
  typedef struct packed {
    logic [PIX_W-1:0] pixel;
    pixel_meta_t      meta;
  } pixel_entry_t;
  pixel_entry_t wr_entry, rd_entry;
  logic push, pop, full, empty, drop;
  logic overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  assign pop  = ~empty & bus.out_ready;
  assign push = bus.in_valid & (~full | pop);
  assign drop = bus.in_valid & full & ~pop;
  assign wr_entry.pixel    = bus.in_pixel;
  assign wr_entry.meta.row = bus.in_row;
  assign wr_entry.meta.col = bus.in_col;
  assign wr_entry.meta.sof = bus.in_row == '0 && bus.in_col == '0;
  assign wr_entry.meta.eol = bus.in_col == coord_t'(FRAME_W - 1);
  pixel_sync_fifo #(.W($bits(pixel_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .level_o (bus.level),
    .full_o  (full),
    .empty_o (empty)
  );
  assign bus.out_valid = ~empty;
  assign bus.out_pixel = rd_entry.pixel;
  assign bus.out_row   = rd_entry.meta.row;
  assign bus.out_col   = rd_entry.meta.col;
  assign bus.out_sof   = rd_entry.meta.sof;
  assign bus.out_eol   = rd_entry.meta.eol;
  // drop accounting: a drop in the same cycle as a clear wins and restarts the count at one
  always_comb begin
    overflow_d = drop | (~bus.clr_flags & overflow_q);
    drop_cnt_d = bus.clr_flags ? {15'd0, drop}
               : (drop && drop_cnt_q != DROP_CNT_MAX) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end
  // sticky drop flag and saturating drop counter
  always_ff @(posedge clk)
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  assign bus.overflow = overflow_q;
  assign bus.drop_cnt = drop_cnt_q;
`ifdef PIXEL_BRIDGE_COORD_CHECK_EN
  coord_t exp_row_q, exp_row_d, exp_col_q, exp_col_d;
  logic armed_q, armed_d, coord_err_q, coord_err_d, bad;
  // expectation follows every strobed pixel (kept or dropped) and resyncs to its coordinate
  always_comb begin
    bad = bus.in_valid & armed_q & ~wr_entry.meta.sof
        & ~(bus.in_row == exp_row_q && bus.in_col == exp_col_q);
    armed_d     = armed_q | bus.in_valid;
    exp_row_d   = ~bus.in_valid ? exp_row_q : wr_entry.meta.eol ? bus.in_row + 16'd1 : bus.in_row;
    exp_col_d   = ~bus.in_valid ? exp_col_q : wr_entry.meta.eol ? '0 : bus.in_col + 16'd1;
    coord_err_d = bad | (~bus.clr_flags & coord_err_q);
  end
  // checker state; the first pixel after reset is accepted unconditionally
  always_ff @(posedge clk)
    if (!rst_n) begin
      armed_q     <= 1'b0;
      exp_row_q   <= '0;
      exp_col_q   <= '0;
      coord_err_q <= 1'b0;
    end else begin
      armed_q     <= armed_d;
      exp_row_q   <= exp_row_d;
      exp_col_q   <= exp_col_d;
      coord_err_q <= coord_err_d;
    end
  assign bus.coord_err = coord_err_q;
`else
  assign bus.coord_err = 1'b0;
`endif
endmodule

// File: tb/tb_pixel_stream_bridge.sv
// tb_pixel_stream_bridge: directed and randomized checks against a queue-based reference model
module tb_pixel_stream_bridge;
  localparam int NUM_CH  = 3;
  localparam int CH_W    = 8;
  localparam int PIX_W   = NUM_CH * CH_W;
  localparam int DEPTH   = 16;
  localparam int FRAME_W = 4;
`ifdef PIXEL_BRIDGE_COORD_CHECK_EN
  localparam bit COORD_EN = 1'b1;
`else
  localparam bit COORD_EN = 1'b0;
`endif
  typedef struct {
    logic [PIX_W-1:0] pix;
    logic [15:0]      row;
    logic [15:0]      col;
  } ent_t;
  logic clk, rst_n;
  pixel_stream_if #(.PIX_W(PIX_W), .LVL_W(5)) bus ();
  pixel_stream_bridge #(
    .FP_M(8), .FP_N(0), .FP_S(0), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .FRAME_W(FRAME_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  ent_t mq[$];
  bit m_ovf, m_cerr, has_exp;
  int m_dcnt;
  logic [15:0] exp_r, exp_c;
  int n_chk, n_err;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input bit v, input logic [PIX_W-1:0] pix, input int r, input int c,
                       input bit rdy, input bit clr);
    bus.in_valid  = v;
    bus.in_pixel  = pix;
    bus.in_row    = 16'(r);
    bus.in_col    = 16'(c);
    bus.out_ready = rdy;
    bus.clr_flags = clr;
  endtask
  task automatic compare_model();
    check("level", 64'(bus.level), 64'(mq.size()));
    check("valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("pixel", 64'(bus.out_pixel), 64'(mq[0].pix));
      check("row", 64'(bus.out_row), 64'(mq[0].row));
      check("col", 64'(bus.out_col), 64'(mq[0].col));
      check("sof", 64'(bus.out_sof), 64'(mq[0].row == 0 && mq[0].col == 0));
      check("eol", 64'(bus.out_eol), 64'(mq[0].col == FRAME_W - 1));
    end
    check("overflow", 64'(bus.overflow), 64'(m_ovf));
    check("drop_cnt", 64'(bus.drop_cnt), 64'(m_dcnt));
    check("coord_err", 64'(bus.coord_err), 64'(m_cerr));
  endtask
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_dcnt = 0; m_cerr = 0; has_exp = 0;
    end else begin
      bit pop, full, drop, bad;
      ent_t e;
      pop  = mq.size() > 0 && bus.out_ready;
      full = mq.size() == DEPTH;
      drop = bus.in_valid && full && !pop;
      bad  = 0;
      if (pop) void'(mq.pop_front());
      if (bus.in_valid && !drop) begin
        e.pix = bus.in_pixel; e.row = bus.in_row; e.col = bus.in_col;
        mq.push_back(e);
      end
      if (drop) begin
        m_ovf = 1;
        m_dcnt = bus.clr_flags ? 1 : (m_dcnt == 65535 ? 65535 : m_dcnt + 1);
      end else if (bus.clr_flags) begin
        m_ovf = 0; m_dcnt = 0;
      end
      if (bus.in_valid) begin
        bad = has_exp && !(bus.in_row == 0 && bus.in_col == 0)
            && !(bus.in_row == exp_r && bus.in_col == exp_c);
        has_exp = 1;
        if (bus.in_col == FRAME_W - 1) begin exp_r = bus.in_row + 16'd1; exp_c = 0; end
        else begin exp_r = bus.in_row; exp_c = bus.in_col + 16'd1; end
      end
      m_cerr = COORD_EN && (bad || (!bus.clr_flags && m_cerr));
    end
    @(negedge clk);
    compare_model();
  endtask
  task automatic reset_dut();
    rst_n = 0;
    drive(0, '0, 0, 0, 0, 0);
    tick();
    rst_n = 1;
  endtask
  initial begin
    logic [PIX_W-1:0] p;
    logic [CH_W-1:0] ch [NUM_CH];
    int r, c;
    n_chk = 0; n_err = 0;
    rst_n = 0;
    drive(0, '0, 0, 0, 0, 0);
    @(negedge clk);
    // 1: reset values, single pixel latency and sof
    reset_dut();
    check("rst_pixel", 64'(bus.out_pixel), 0);
    check("rst_row", 64'(bus.out_row), 0);
    check("rst_sof", 64'(bus.out_sof), 0);
    check("rst_eol", 64'(bus.out_eol), 0);
    drive(1, 24'hA5, 0, 0, 1, 0);
    tick();
    check("t1_valid", 64'(bus.out_valid), 1);
    check("t1_sof", 64'(bus.out_sof), 1);
    check("t1_pixel", 64'(bus.out_pixel), 64'h0000A5);
    drive(0, '0, 0, 0, 1, 0);
    tick();
    check("t1_level0", 64'(bus.level), 0);
    // 2: overflow with 20 pixels into a stalled FIFO, then in-order drain
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      drive(1, PIX_W'(i * 7 + 1), i / FRAME_W, i % FRAME_W, 0, 0);
      tick();
    end
    check("t2_level", 64'(bus.level), 16);
    check("t2_drop", 64'(bus.drop_cnt), 4);
    check("t2_ovf", 64'(bus.overflow), 1);
    for (int i = 0; i < 16; i++) begin
      check("t2_order", 64'(bus.out_pixel), 64'(i * 7 + 1));
      drive(0, '0, 0, 0, 1, 0);
      tick();
    end
    check("t2_empty", 64'(bus.out_valid), 0);
    // 3: push and pop on a full FIFO, then clear racing a drop
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      drive(1, PIX_W'($urandom), i / FRAME_W, i % FRAME_W, 0, 0);
      tick();
    end
    drive(1, 24'h123456, 4, 0, 1, 0);
    tick();
    check("t3_level", 64'(bus.level), 16);
    check("t3_drop", 64'(bus.drop_cnt), 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 24'h0, 4, 1 + i, 0, 0);
      tick();
    end
    check("t3_drop2", 64'(bus.drop_cnt), 2);
    drive(1, 24'h0, 4, 3, 0, 1);
    tick();
    check("t3_clr_drop", 64'(bus.drop_cnt), 1);
    check("t3_clr_ovf", 64'(bus.overflow), 1);
    drive(0, '0, 0, 0, 0, 1);
    tick();
    check("t3_clr", 64'(bus.drop_cnt), 0);
    // 4: two-row raster, eol and per-channel placement
    reset_dut();
    for (int i = 0; i < 2 * FRAME_W; i++) begin
      for (int k = 0; k < NUM_CH; k++) ch[k] = CH_W'($urandom);
      p = {ch[2], ch[1], ch[0]};
      drive(1, p, i / FRAME_W, i % FRAME_W, 1, 0);
      tick();
      check("t4_eol", 64'(bus.out_eol), 64'(i % FRAME_W == FRAME_W - 1));
      for (int k = 0; k < NUM_CH; k++) check("t4_ch", 64'(bus.out_pixel[k*CH_W +: CH_W]), 64'(ch[k]));
    end
    // 5: raster-order checker
    reset_dut();
    drive(1, 24'h1, 0, 0, 1, 0); tick();
    drive(1, 24'h2, 0, 1, 1, 0); tick();
    check("t5_ok", 64'(bus.coord_err), 0);
    drive(1, 24'h3, 0, 3, 1, 0); tick();
    check("t5_err", 64'(bus.coord_err), 64'(COORD_EN));
    drive(0, '0, 0, 0, 1, 1); tick();
    check("t5_clr", 64'(bus.coord_err), 0);
    drive(1, 24'h4, 0, 0, 1, 0); tick();
    drive(1, 24'h5, 0, 1, 1, 0); tick();
    drive(1, 24'h6, 0, 0, 1, 0); tick();
    check("t5_sof_mid", 64'(bus.coord_err), 0);
    // 6: reset mid-burst
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      drive(1, PIX_W'($urandom), 0, i % FRAME_W, 0, 0);
      tick();
    end
    check("t6_level5", 64'(bus.level), 5);
    rst_n = 0;
    drive(1, 24'hFFFFFF, 9, 9, 0, 0);
    tick();
    rst_n = 1;
    check("t6_level", 64'(bus.level), 0);
    check("t6_valid", 64'(bus.out_valid), 0);
    check("t6_pixel", 64'(bus.out_pixel), 0);
    check("t6_ovf", 64'(bus.overflow), 0);
    // random traffic with mostly raster coordinates and occasional jumps
    reset_dut();
    r = 0; c = 0;
    for (int i = 0; i < 600; i++) begin
      bit v;
      v = $urandom_range(0, 99) < 70;
      if ($urandom_range(0, 99) < 5) begin r = $urandom_range(0, 3); c = $urandom_range(0, 5); end
      drive(v, PIX_W'($urandom), r, c, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 4);
      tick();
      if (v) begin
        c++;
        if (c >= FRAME_W) begin c = 0; r++; end
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
